// File: rtl/systolic_gemm_engine_if.sv
// -----------------------------------------------------------------------------
// systolic_gemm_engine_if
// Bundles the job handshake and the single-port memory bus of the GEMM engine.
//   start/addr_A/addr_B/addr_C/n/shift/sat_en : job request (host -> engine)
//   busy/done/fsm_state                        : status (engine -> host)
//   mem_addr/mem_wren/mem_wdata                : memory request (engine -> mem)
//   mem_rdata                                  : memory read data (mem -> engine)
// master = host/memory side, slave = engine side.
// -----------------------------------------------------------------------------
interface systolic_gemm_engine_if #(
  parameter int N      = 4,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 12
);
  logic                     start;
  logic [ADDR_W-1:0]        addr_A;
  logic [ADDR_W-1:0]        addr_B;
  logic [ADDR_W-1:0]        addr_C;
  logic [$clog2(N+1)-1:0]   n;
  logic [5:0]               shift;
  logic                     sat_en;
  logic                     busy;
  logic                     done;
  logic [2:0]               fsm_state;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_wren;
  logic [WIDTH-1:0]         mem_wdata;
  logic [WIDTH-1:0]         mem_rdata;

  modport master (
    output start, addr_A, addr_B, addr_C, n, shift, sat_en, mem_rdata,
    input  busy, done, fsm_state, mem_addr, mem_wren, mem_wdata
  );

  modport slave (
    input  start, addr_A, addr_B, addr_C, n, shift, sat_en, mem_rdata,
    output busy, done, fsm_state, mem_addr, mem_wren, mem_wdata
  );
endinterface

// File: rtl/systolic_gemm_engine.sv
// -----------------------------------------------------------------------------
// systolic_gemm_engine
// Weight-stationary N x N systolic engine computing C = A x B for signed n x n
// row-major matrices (n <= N) held in a single-port word memory. B is loaded
// as stationary weights, A is buffered and streamed with diagonal skew, and C
// is written back after an arithmetic right shift and optional saturation.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : job handshake + memory bus (slave side of systolic_gemm_engine_if)
// -----------------------------------------------------------------------------
module systolic_gemm_engine #(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40,
  parameter int ADDR_W    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_gemm_engine_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int NW = $clog2(N + 1);
  localparam int CW = $clog2(N * N + 3 * N + 1);
  localparam logic [CW-1:0] COMPUTE_LAST = CW'(3 * N - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ~ACC_MAX;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD_B = 3'd1, S_LOAD_A = 3'd2,
    S_COMPUTE = 3'd3, S_WRITE = 3'd4, S_DONE = 3'd5
  } state_t;

  state_t                       r_state, w_next;
  logic [CW-1:0]                r_cnt, r_nsq;
  logic [IW-1:0]                r_i, r_j;
  logic [NW-1:0]                r_n, w_n_clamp;
  logic [ADDR_W-1:0]            r_addr_a, r_addr_b, r_addr_c;
  logic [5:0]                   r_shift;
  logic                         r_sat;
  logic                         w_last;

  logic signed [WIDTH-1:0]      r_wbuf [N][N];
  logic signed [WIDTH-1:0]      r_abuf [N][N];
  logic signed [ACC_WIDTH-1:0]  r_cbuf [N][N];
  logic signed [WIDTH-1:0]      r_a    [N][N];
  logic signed [ACC_WIDTH-1:0]  r_psum [N][N];

  logic signed [WIDTH-1:0]      w_feed  [N];
  logic signed [WIDTH-1:0]      w_a_in  [N][N];
  logic signed [2*WIDTH-1:0]    w_prod  [N][N];
  logic signed [ACC_WIDTH-1:0]  w_mac   [N][N];
  logic                         w_cap_en  [N];
  logic [IW-1:0]                w_cap_row [N];
  logic signed [ACC_WIDTH-1:0]  w_shifted;
  logic [WIDTH-1:0]             w_narrow;

  assign w_n_clamp = (bus.n > NW'(N)) ? NW'(N) : bus.n;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next = r_state;
    w_last = (r_state == S_COMPUTE) ? (r_cnt == COMPUTE_LAST)
                                    : (r_cnt == r_nsq - CW'(1));
    case (r_state)
      S_IDLE:    if (bus.start) w_next = (w_n_clamp == '0) ? S_DONE : S_LOAD_B;
      S_LOAD_B:  if (w_last) w_next = S_LOAD_A;
      S_LOAD_A:  if (w_last) w_next = S_COMPUTE;
      S_COMPUTE: if (w_last) w_next = S_WRITE;
      S_WRITE:   if (w_last) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Row-major addressing is contiguous, so the phase counter is the offset.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    w_shifted     = r_cbuf[r_i][r_j] >>> r_shift;
    if (!r_sat)                  w_narrow = w_shifted[WIDTH-1:0];
    else if (w_shifted > ACC_MAX) w_narrow = ACC_MAX[WIDTH-1:0];
    else if (w_shifted < ACC_MIN) w_narrow = ACC_MIN[WIDTH-1:0];
    else                          w_narrow = w_shifted[WIDTH-1:0];
    case (r_state)
      S_LOAD_B: bus.mem_addr = r_addr_b + ADDR_W'(r_cnt);
      S_LOAD_A: bus.mem_addr = r_addr_a + ADDR_W'(r_cnt);
      S_WRITE: begin
        bus.mem_addr  = r_addr_c + ADDR_W'(r_cnt);
        bus.mem_wdata = w_narrow;
      end
      default: ;
    endcase
  end

  assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.mem_wren  = (r_state == S_WRITE);
  assign bus.fsm_state = r_state;

  // Array row k consumes column k of A (A[i][k] at compute cycle i+k), so the
  // bottom of column c carries row i of C at compute cycle i+N+c.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      w_feed[r] = '0;
      if (r_state == S_COMPUTE && int'(r_cnt) >= r && int'(r_cnt) - r < N)
        w_feed[r] = r_abuf[IW'(int'(r_cnt) - r)][r];
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        w_a_in[r][c] = (c == 0) ? w_feed[r] : r_a[r][(c == 0) ? 0 : c - 1];
        w_prod[r][c] = w_a_in[r][c] * r_wbuf[r][c];
        w_mac[r][c]  = ((r == 0) ? '0 : r_psum[(r == 0) ? 0 : r - 1][c])
                       + ACC_WIDTH'(w_prod[r][c]);
      end
    end
    for (int c = 0; c < N; c++) begin
      w_cap_en[c]  = 1'b0;
      w_cap_row[c] = '0;
      if (r_state == S_COMPUTE && int'(r_cnt) >= N + c && int'(r_cnt) < 2 * N + c) begin
        w_cap_en[c]  = 1'b1;
        w_cap_row[c] = IW'(int'(r_cnt) - N - c);
      end
    end
  end

  // PE pipeline registers: only the diagonal window of the compute phase is
  // ever captured, so stale contents from earlier jobs never reach C.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          r_a[r][c]    <= '0;
          r_psum[r][c] <= '0;
        end
    end else if (r_state == S_COMPUTE) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          r_a[r][c]    <= w_a_in[r][c];
          r_psum[r][c] <= w_mac[r][c];
        end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the operand buffers are cleared on reset because a short job reads
  // its zero padding from them; clearing on start handles entries >= n.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_nsq    <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_n      <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_c <= '0;
      r_shift  <= '0;
      r_sat    <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          r_wbuf[r][c] <= '0;
          r_abuf[r][c] <= '0;
          r_cbuf[r][c] <= '0;
        end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_addr_a <= bus.addr_A;
          r_addr_b <= bus.addr_B;
          r_addr_c <= bus.addr_C;
          r_shift  <= bus.shift;
          r_sat    <= bus.sat_en;
          r_n      <= w_n_clamp;
          r_nsq    <= CW'(w_n_clamp) * CW'(w_n_clamp);
          r_cnt    <= '0;
          r_i      <= '0;
          r_j      <= '0;
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
              r_wbuf[r][c] <= '0;
              r_abuf[r][c] <= '0;
              r_cbuf[r][c] <= '0;
            end
        end
        S_LOAD_B, S_LOAD_A, S_WRITE: begin
          // Read data for this cycle's address is valid at the closing edge.
          if (r_state == S_LOAD_B) r_wbuf[r_i][r_j] <= bus.mem_rdata;
          if (r_state == S_LOAD_A) r_abuf[r_i][r_j] <= bus.mem_rdata;
          if (w_last) begin
            r_cnt <= '0;
            r_i   <= '0;
            r_j   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (NW'(r_j) == r_n - NW'(1)) begin
              r_j <= '0;
              r_i <= r_i + IW'(1);
            end else begin
              r_j <= r_j + IW'(1);
            end
          end
        end
        S_COMPUTE: begin
          r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          for (int c = 0; c < N; c++)
            if (w_cap_en[c]) r_cbuf[w_cap_row[c]][c] <= r_psum[N-1][c];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// -----------------------------------------------------------------------------
// tb_systolic_gemm_engine
// Table of directed GEMM jobs with hand-computed results, plus hand-written
// sequences for start-during-compute, reset mid-write and address wrap.
// A behavioural negedge-clocked memory model serves the engine.
// -----------------------------------------------------------------------------
module tb_systolic_gemm_engine;
  localparam int N      = 4;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 12;
  localparam int NW     = $clog2(N + 1);

  typedef struct {
    int               n_in;
    int               n_eff;
    int               shift;
    bit               sat;
    int               lat;
    logic [15:0][15:0] a;
    logic [15:0][15:0] b;
    logic [15:0][15:0] c;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_gemm_engine_if #(.N(N), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  systolic_gemm_engine #(.N(N), .WIDTH(WIDTH), .ACC_WIDTH(40), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [WIDTH-1:0]  mem [4096];
  logic              tb_we = 1'b0;
  logic [ADDR_W-1:0] tb_addr = '0;
  logic [WIDTH-1:0]  tb_data = '0;
  logic              prev_wren = 1'b0;
  int cyc = 0, wr_total = 0, wr_runs = 0, done_total = 0;
  int base_wr, base_runs, base_done;
  int checks = 0, failures = 0;
  vec_t vecs[9];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_wren) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_total <= wr_total + 1;
      if (!prev_wren) wr_runs <= wr_runs + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
    prev_wren     <= bus.mem_wren;
    if (bus.done) done_total <= done_total + 1;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] s16(input int x);
    return x[15:0];
  endfunction

  function automatic vec_t mk(input int n_in, input int n_eff, input int sh,
                              input bit sat, input int lat);
    vec_t v;
    v.n_in = n_in; v.n_eff = n_eff; v.shift = sh; v.sat = sat; v.lat = lat;
    v.a = '0; v.b = '0; v.c = '0;
    return v;
  endfunction

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    tb_addr = a; tb_data = d; tb_we = 1'b1;
    @(negedge clk); #1;
    tb_we = 1'b0;
  endtask

  // Loads operands, fills C region (+1 word) with a sentinel, issues start.
  task automatic launch(input int vi, input logic [ADDR_W-1:0] ac, output int k);
    int ne = vecs[vi].n_eff;
    for (int t = 0; t < 200 && bus.fsm_state != 3'd0; t++) @(negedge clk);
    for (int i = 0; i < ne * ne; i++) begin
      poke(12'h100 + 12'(i), vecs[vi].a[i]);
      poke(12'h200 + 12'(i), vecs[vi].b[i]);
    end
    for (int i = 0; i <= ne * ne; i++) poke(ac + 12'(i), 16'h5A5A);
    base_wr = wr_total; base_runs = wr_runs; base_done = done_total;
    bus.addr_A = 12'h100; bus.addr_B = 12'h200; bus.addr_C = ac;
    bus.n = NW'(vecs[vi].n_in); bus.shift = 6'(vecs[vi].shift);
    bus.sat_en = vecs[vi].sat; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = cyc;
    check($sformatf("v%0d accept_state", vi), bus.fsm_state, (ne == 0) ? 5 : 1);
  endtask

  task automatic run_vec(input int vi, input logic [ADDR_W-1:0] ac, input bit pulse);
    int k, lat, ne;
    bit pulsed;
    ne = vecs[vi].n_eff; lat = -1; pulsed = 0;
    launch(vi, ac, k);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); #1;
      bus.start = 1'b0;
      if (pulse && !pulsed && bus.fsm_state == 3'd3) begin
        bus.start = 1'b1;
        pulsed = 1;
      end
      if (bus.done) begin
        lat = cyc - k + 1;
        check($sformatf("v%0d busy_at_done", vi), bus.busy, 0);
        break;
      end
    end
    check($sformatf("v%0d done_latency", vi), lat, vecs[vi].lat);
    check($sformatf("v%0d write_count", vi), wr_total - base_wr, ne * ne);
    check($sformatf("v%0d write_bursts", vi), wr_runs - base_runs, (ne > 0) ? 1 : 0);
    for (int i = 0; i < ne * ne; i++)
      check($sformatf("v%0d C[%0d]", vi, i), mem[ac + 12'(i)], vecs[vi].c[i]);
    check($sformatf("v%0d no_overrun", vi), mem[ac + 12'(ne * ne)], 16'h5A5A);
    if (pulse) begin
      repeat (8) @(negedge clk);
      check($sformatf("v%0d single_done", vi), done_total - base_done, 1);
      check($sformatf("v%0d idle_after", vi), bus.fsm_state, 0);
    end
  endtask

  initial begin
    int k;
    // 0: identity B, n=4
    vecs[0] = mk(4, 4, 0, 0, 61);
    for (int i = 0; i < 16; i++) begin
      vecs[0].a[i] = 16'(i);
      vecs[0].b[i] = (i % 5 == 0) ? 16'd1 : 16'd0;
      vecs[0].c[i] = 16'(i);
    end
    // 1: signed 2x2
    vecs[1] = mk(2, 2, 0, 0, 25);
    vecs[1].a[0] = s16(-3); vecs[1].a[1] = 16'd2; vecs[1].a[2] = 16'd1; vecs[1].a[3] = s16(-1);
    vecs[1].b[0] = 16'd4; vecs[1].b[1] = s16(-5); vecs[1].b[2] = 16'd7; vecs[1].b[3] = 16'd6;
    vecs[1].c[0] = 16'd2; vecs[1].c[1] = 16'd27; vecs[1].c[2] = s16(-3); vecs[1].c[3] = s16(-11);
    // 2..4: 30000*30000 = 900000000 = 0x35A4E900
    vecs[2] = mk(1, 1, 0, 1, 16);
    vecs[2].a[0] = 16'd30000; vecs[2].b[0] = 16'd30000; vecs[2].c[0] = 16'h7FFF;
    vecs[3] = vecs[2]; vecs[3].sat = 0;  vecs[3].c[0] = 16'hE900;
    vecs[4] = vecs[2]; vecs[4].shift = 16; vecs[4].c[0] = 16'd13732;
    // 5: n=7 clamps to 4; A all ones, B[k]=k -> C[i][j] = 24 + 4j
    vecs[5] = mk(7, 4, 0, 0, 61);
    for (int i = 0; i < 16; i++) begin
      vecs[5].a[i] = 16'd1;
      vecs[5].b[i] = 16'(i);
      vecs[5].c[i] = 16'(24 + 4 * (i % 4));
    end
    // 6: negative saturation
    vecs[6] = mk(2, 2, 0, 1, 25);
    vecs[6].a[0] = s16(-30000); vecs[6].b[0] = 16'd30000; vecs[6].c[0] = 16'h8000;
    // 7: arithmetic shift of signed results (floor)
    vecs[7] = vecs[1]; vecs[7].shift = 2;
    vecs[7].c[0] = 16'd0; vecs[7].c[1] = 16'd6; vecs[7].c[2] = s16(-1); vecs[7].c[3] = s16(-3);
    // 8: n=0, immediate done, no memory traffic
    vecs[8] = mk(0, 0, 0, 0, 1);

    bus.start = 1'b0; bus.addr_A = '0; bus.addr_B = '0; bus.addr_C = '0;
    bus.n = '0; bus.shift = '0; bus.sat_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy",      bus.busy, 0);
    check("reset done",      bus.done, 0);
    check("reset mem_wren",  bus.mem_wren, 0);
    check("reset mem_addr",  bus.mem_addr, 0);
    check("reset mem_wdata", bus.mem_wdata, 0);
    check("reset fsm_state", bus.fsm_state, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int vi = 0; vi < 9; vi++) run_vec(vi, 12'h300 + 12'(vi * 32), 0);

    // start pulsed during COMPUTE must be ignored
    run_vec(1, 12'h600, 1);

    // C address wraps: 4094, 4095, 0, 1
    run_vec(1, 12'hFFE, 0);
    check("wrap mem[0]", mem[0], 16'hFFFD);
    check("wrap mem[1]", mem[1], 16'hFFF5);

    // reset after three writes of a job
    launch(1, 12'h700, k);
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #1;
      if (wr_total - base_wr == 3) break;
    end
    check("rst writes_before", wr_total - base_wr, 3);
    rst = 1'b0;
    #1;
    check("rst busy",      bus.busy, 0);
    check("rst done",      bus.done, 0);
    check("rst mem_wren",  bus.mem_wren, 0);
    check("rst mem_addr",  bus.mem_addr, 0);
    check("rst fsm_state", bus.fsm_state, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst writes_after", wr_total - base_wr, 3);
    check("rst kept C0", mem[12'h700], 16'd2);
    check("rst kept C1", mem[12'h701], 16'd27);
    check("rst kept C2", mem[12'h702], 16'hFFFD);
    check("rst no C3",   mem[12'h703], 16'h5A5A);
    run_vec(0, 12'h720, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
